// File: rtl/rv32i_decode_exec.sv
// RV32I decode, ALU, branch resolution and 32x32 register file; all outputs are combinational from instr_i/pc_i.
// Defining RV_ILLEGAL_FLAG_EN adds illegal_o, which suppresses writes and jumps for malformed instructions.
module rv32i_decode_exec #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] load_data_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            jump_ok_o,
    output logic [XLEN-1:0] jump_pc_o,
    output logic [XLEN-1:0] alu_out_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_addr_o,
    output logic [XLEN-1:0] reg_data_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [1:0]      mem_size_o
`ifdef RV_ILLEGAL_FLAG_EN
    ,
    output logic            illegal_o
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_LOAD} wb_sel_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign rd     = instr_i[11:7];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    logic [XLEN-1:0] regs [0:31];
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we_o && rd != 5'd0) begin
            regs[rd] <= reg_data_o;
        end
    end

    alu_op_t         alu_op;
    wb_sel_t         wb_sel;
    logic [XLEN-1:0] op_a, op_b;
    logic            wb_en, is_load, is_store, store_ok, is_jump, is_branch, alt_op;

    // OP-IMM only honours instr[30] on right shifts; OP honours it for ADD/SUB and SRL/SRA.
    always_comb begin
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        op_a      = rs1_val;
        op_b      = imm_i;
        wb_en     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        store_ok  = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        alt_op    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                op_b   = imm_u;
                alu_op = ALU_PASSB;
                wb_en  = 1'b1;
            end
            OPC_AUIPC: begin
                op_a  = pc_i;
                op_b  = imm_u;
                wb_en = 1'b1;
            end
            OPC_JAL: begin
                op_a    = pc_i;
                op_b    = imm_j;
                wb_en   = 1'b1;
                wb_sel  = WB_PC4;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                wb_en   = 1'b1;
                wb_sel  = WB_PC4;
                is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                op_b      = rs2_val;
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            OPC_LOAD: begin
                is_load = 1'b1;
                wb_en   = 1'b1;
                wb_sel  = WB_LOAD;
            end
            OPC_STORE: begin
                op_b     = imm_s;
                is_store = 1'b1;
                store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OPC_OPIMM, OPC_OP: begin
                wb_en = 1'b1;
                if (opcode == OPC_OP) begin
                    op_b   = rs2_val;
                    alt_op = instr_i[30];
                end else begin
                    alt_op = instr_i[30] && (funct3 == 3'b101);
                end
                case (funct3)
                    3'b000:  alu_op = alt_op ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = alt_op ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: ;
        endcase
    end

    logic [4:0] shamt;
    assign shamt = op_b[4:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_out_o = op_a + op_b;
            ALU_SUB:   alu_out_o = op_a - op_b;
            ALU_SLL:   alu_out_o = op_a << shamt;
            ALU_SLT:   alu_out_o = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_out_o = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu_out_o = op_a ^ op_b;
            ALU_SRL:   alu_out_o = op_a >> shamt;
            ALU_SRA:   alu_out_o = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:    alu_out_o = op_a | op_b;
            ALU_AND:   alu_out_o = op_a & op_b;
            default:   alu_out_o = op_b;
        endcase
    end

    logic taken;
    always_comb begin
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val < rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] load_val;
    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{load_data_i[7]}}, load_data_i[7:0]};
            3'b001:  load_val = {{16{load_data_i[15]}}, load_data_i[15:0]};
            3'b010:  load_val = load_data_i;
            3'b100:  load_val = {24'b0, load_data_i[7:0]};
            3'b101:  load_val = {16'b0, load_data_i[15:0]};
            default: load_val = '0;
        endcase
    end

    logic kill;
`ifdef RV_ILLEGAL_FLAG_EN
    logic illegal;
    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM: illegal = 1'b0;
            OPC_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OPC_STORE:  illegal = !store_ok;
            OPC_OP:     illegal = (instr_i[31:25] != 7'b0000000) && (instr_i[31:25] != 7'b0100000);
            default:    illegal = 1'b1;
        endcase
    end
    assign illegal_o = illegal;
    assign kill      = illegal;
`else
    assign kill = 1'b0;
`endif

    logic            active;
    logic [XLEN-1:0] pc_plus4, target, wb_val;

    assign active   = !rst_i && !kill;
    assign pc_plus4 = pc_i + XLEN'(4);

    always_comb begin
        if (opcode == OPC_JALR)
            target = {alu_out_o[XLEN-1:1], 1'b0};
        else if (is_branch)
            target = pc_i + imm_b;
        else
            target = alu_out_o;
    end

    always_comb begin
        case (wb_sel)
            WB_PC4:  wb_val = pc_plus4;
            WB_LOAD: wb_val = load_val;
            default: wb_val = alu_out_o;
        endcase
    end

    assign jump_ok_o   = active && (is_jump || (is_branch && taken));
    assign jump_pc_o   = jump_ok_o ? target : '0;
    assign next_pc_o   = rst_i ? RESET_PC : (jump_ok_o ? target : pc_plus4);
    assign reg_we_o    = active && wb_en;
    assign reg_addr_o  = reg_we_o ? rd : 5'd0;
    assign reg_data_o  = reg_we_o ? wb_val : '0;
    assign mem_we_o    = active && is_store && store_ok;
    assign mem_addr_o  = (is_load || is_store) ? alu_out_o : '0;
    assign mem_wdata_o = is_store ? rs2_val : '0;
    assign mem_size_o  = funct3[1:0];

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Randomized and directed bench for rv32i_decode_exec against an ISA-level reference model.
module tb_rv32i_decode_exec;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i, pc_i, load_data_i;
    logic [31:0] next_pc_o, jump_pc_o, alu_out_o, reg_data_o, mem_addr_o, mem_wdata_o;
    logic        jump_ok_o, reg_we_o, mem_we_o;
    logic [4:0]  reg_addr_o;
    logic [1:0]  mem_size_o;
`ifdef RV_ILLEGAL_FLAG_EN
    logic        illegal_o;
`endif

    rv32i_decode_exec #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
        .load_data_i(load_data_i), .next_pc_o(next_pc_o), .jump_ok_o(jump_ok_o),
        .jump_pc_o(jump_pc_o), .alu_out_o(alu_out_o), .reg_we_o(reg_we_o),
        .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o)
`ifdef RV_ILLEGAL_FLAG_EN
        , .illegal_o(illegal_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference architectural state and expected outputs
    logic [31:0] mregs [32];
    logic [31:0] e_next, e_jpc, e_rdata, e_maddr, e_mwdata, e_alu;
    logic        e_jump, e_we, e_mwe, e_alu_chk, e_ill;
    logic [4:0]  e_rd;

    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b, ii, is, ib, iu, ij, tgt, wd;
        logic        jmp, we, mwe, tk;
        op = instr_i[6:0];
        f3 = instr_i[14:12];
        a  = (instr_i[19:15] == 0) ? 32'd0 : mregs[instr_i[19:15]];
        b  = (instr_i[24:20] == 0) ? 32'd0 : mregs[instr_i[24:20]];
        ii = {{20{instr_i[31]}}, instr_i[31:20]};
        is = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        ib = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        iu = {instr_i[31:12], 12'b0};
        ij = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        tgt = 0; wd = 0; jmp = 0; we = 0; mwe = 0; e_ill = 0;
        e_alu = 0; e_alu_chk = 0; e_maddr = 0; e_mwdata = 0;
        case (op)
            7'b0110111: begin we = 1; wd = iu; e_alu = iu; e_alu_chk = 1; end
            7'b0010111: begin we = 1; wd = pc_i + iu; e_alu = wd; e_alu_chk = 1; end
            7'b1101111: begin we = 1; wd = pc_i + 4; jmp = 1; tgt = pc_i + ij; end
            7'b1100111: begin we = 1; wd = pc_i + 4; jmp = 1; tgt = (a + ii) & ~32'd1; end
            7'b1100011: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: begin tk = 0; e_ill = 1; end
                endcase
                jmp = tk; tgt = pc_i + ib;
            end
            7'b0000011: begin
                we = 1; e_maddr = a + ii; e_alu = e_maddr; e_alu_chk = 1;
                case (f3)
                    3'd0: wd = 32'($signed(load_data_i[7:0]));
                    3'd1: wd = 32'($signed(load_data_i[15:0]));
                    3'd2: wd = load_data_i;
                    3'd4: wd = {24'd0, load_data_i[7:0]};
                    3'd5: wd = {16'd0, load_data_i[15:0]};
                    default: begin wd = 0; e_ill = 1; end
                endcase
            end
            7'b0100011: begin
                e_maddr = a + is; e_alu = e_maddr; e_alu_chk = 1; e_mwdata = b;
                mwe = (f3 <= 3'd2);
                e_ill = !mwe;
            end
            7'b0010011: begin
                we = 1; wd = arith(f3, instr_i[30] && f3 == 3'd5, a, ii, instr_i[24:20]);
                e_alu = wd; e_alu_chk = 1;
            end
            7'b0110011: begin
                we = 1; wd = arith(f3, instr_i[30], a, b, b[4:0]);
                e_alu = wd; e_alu_chk = 1;
                e_ill = (instr_i[31:25] != 7'h00) && (instr_i[31:25] != 7'h20);
            end
            default: e_ill = 1;
        endcase
`ifdef RV_ILLEGAL_FLAG_EN
        if (e_ill) begin we = 0; mwe = 0; jmp = 0; end
`endif
        if (rst_i) begin we = 0; mwe = 0; jmp = 0; end
        e_we     = we;
        e_mwe    = mwe;
        e_jump   = jmp;
        e_jpc    = jmp ? tgt : 32'd0;
        e_rd     = we ? instr_i[11:7] : 5'd0;
        e_rdata  = we ? wd : 32'd0;
        e_next   = rst_i ? RESET_PC : (jmp ? tgt : pc_i + 32'd4);
    endtask

    task automatic compare_all();
        model();
        check("next_pc", next_pc_o, e_next);
        check("jump_ok", {31'd0, jump_ok_o}, {31'd0, e_jump});
        check("jump_pc", jump_pc_o, e_jpc);
        check("reg_we", {31'd0, reg_we_o}, {31'd0, e_we});
        check("reg_addr", {27'd0, reg_addr_o}, {27'd0, e_rd});
        check("reg_data", reg_data_o, e_rdata);
        check("mem_we", {31'd0, mem_we_o}, {31'd0, e_mwe});
        check("mem_addr", mem_addr_o, e_maddr);
        check("mem_wdata", mem_wdata_o, e_mwdata);
        check("mem_size", {30'd0, mem_size_o}, {30'd0, instr_i[13:12]});
        if (e_alu_chk) check("alu_out", alu_out_o, e_alu);
`ifdef RV_ILLEGAL_FLAG_EN
        check("illegal", {31'd0, illegal_o}, {31'd0, e_ill});
`endif
    endtask

    // Called one time unit after a rising edge; samples mid-cycle.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] ld);
        instr_i = ins; pc_i = pc; load_data_i = ld;
        #3;
        compare_all();
    endtask

    task automatic tick();
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
        we = e_we; rd = e_rd; d = e_rdata;
        @(posedge clk_i);
        if (we && rd != 0) mregs[rd] = d;
        #1;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] ld);
        step(ins, pc, ld);
        tick();
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;

    logic [6:0] op_tab [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};

    initial begin
        logic [31:0] ins, pc, ld;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        rst_i = 1'b1;
        instr_i = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPIMM); pc_i = 32'h1234; load_data_i = 0;
        #2;
        compare_all();
        check("rst_next_pc", next_pc_o, RESET_PC);
        check("rst_reg_we", {31'd0, reg_we_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        step(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPIMM), 32'h8000_0000, 0);
        check("addi_data", reg_data_o, 32'd5);
        check("addi_addr", {27'd0, reg_addr_o}, 32'd1);
        check("addi_next", next_pc_o, 32'h8000_0004);
        tick();
        step(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h8000_0004, 0);
        check("add_data", reg_data_o, 32'd10);
        tick();

        run(enc_i(12'hFF0, 5'd0, 3'd0, 5'd1, OPIMM), 32'h8000_0008, 0);
        step(enc_i({7'b0100000, 5'd4}, 5'd1, 3'd5, 5'd3, OPIMM), 32'h8000_000C, 0);
        check("srai", reg_data_o, 32'hFFFF_FFFF);
        tick();
        step(enc_i(12'd4, 5'd1, 3'd5, 5'd3, OPIMM), 32'h8000_000C, 0);
        check("srli", reg_data_o, 32'h0FFF_FFFF);
        tick();
        step(enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4), 32'h8000_000C, 0);
        check("sltu", reg_data_o, 32'd1);
        tick();
        step(enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd4), 32'h8000_000C, 0);
        check("slt", reg_data_o, 32'd1);
        tick();

        step(enc_b(-13'sd8, 5'd0, 5'd0, 3'd0), 32'h8000_0010, 0);
        check("beq_next", next_pc_o, 32'h8000_0008);
        check("beq_jump", {31'd0, jump_ok_o}, 32'd1);
        tick();
        step(enc_b(-13'sd8, 5'd0, 5'd0, 3'd1), 32'h8000_0010, 0);
        check("bne_next", next_pc_o, 32'h8000_0014);
        tick();

        run({20'h80000, 5'd5, 7'b0110111}, 32'h8000_0014, 0);
        run(enc_i(12'h100, 5'd5, 3'd0, 5'd5, OPIMM), 32'h8000_0018, 0);
        step(enc_i(12'd3, 5'd5, 3'd0, 5'd1, 7'b1100111), 32'h8000_0020, 0);
        check("jalr_next", next_pc_o, 32'h8000_0102);
        check("jalr_link", reg_data_o, 32'h8000_0024);
        tick();

        step(enc_i(12'd0, 5'd1, 3'd0, 5'd6, LOAD), 32'h8000_0024, 32'h0000_80F0);
        check("lb", reg_data_o, 32'hFFFF_FFF0);
        tick();
        step(enc_i(12'd0, 5'd1, 3'd4, 5'd6, LOAD), 32'h8000_0028, 32'h0000_80F0);
        check("lbu", reg_data_o, 32'h0000_00F0);
        tick();
        step(enc_i(12'd0, 5'd1, 3'd1, 5'd6, LOAD), 32'h8000_002C, 32'h0000_80F0);
        check("lh", reg_data_o, 32'hFFFF_80F0);
        tick();
        step(enc_s(12'd8, 5'd2, 5'd1, 3'd2), 32'h8000_0030, 0);
        check("sw_we", {31'd0, mem_we_o}, 32'd1);
        check("sw_addr", mem_addr_o, 32'h8000_002C);
        check("sw_wdata", mem_wdata_o, 32'd10);
        check("sw_size", {30'd0, mem_size_o}, 32'd2);
        check("sw_no_rd", {31'd0, reg_we_o}, 32'd0);
        tick();

        run(enc_i(12'd1, 5'd0, 3'd0, 5'd0, OPIMM), 32'h8000_0034, 0);
        step(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 32'h8000_0038, 0);
        check("x0_zero", reg_data_o, 32'd0);
        tick();

        // Asynchronous reset mid-cycle: registers clear at once, edge does not write.
        rst_i = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        step(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 32'h8000_003C, 0);
        check("rst_regs_clear", alu_out_o, 32'd0);
        check("rst_mid_next", next_pc_o, RESET_PC);
        tick();
        rst_i = 1'b0;
        step(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 32'h8000_0000, 0);
        check("post_rst_add", reg_data_o, 32'd0);
        tick();

        for (int r = 1; r < 32; r++) begin
            run({$urandom_range(32'hFFFFF, 0) & 32'hFFFFF, 5'(r), 7'b0110111}, 32'h8000_0000, 0);
            run(enc_i(12'($urandom), 5'(r), 3'd0, 5'(r), OPIMM), 32'h8000_0004, 0);
        end

        for (int n = 0; n < 2000; n++) begin
            ins = $urandom;
            ins[6:0] = op_tab[$urandom_range(10, 0)];
            if (ins[6:0] == 7'b0110011 && $urandom_range(3, 0) != 0)
                ins[31:25] = ins[30] ? 7'h20 : 7'h00;
            if (ins[6:0] == 7'b1100011 && $urandom_range(3, 0) == 0)
                ins[24:20] = ins[19:15];
            pc = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
            ld = $urandom;
            run(ins, pc, ld);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_exec.md
Name: rv32i_decode_exec

Overview:
- Combined decode, execute-control and ALU slice of the RV32I single-cycle core, including the 32x32 integer register file.
- Takes the fetched instruction, the current PC and the data-memory read word.
- Produces the register writeback, the store request, the next PC and branch/jump resolution, all in the same cycle.
- The top-level core owns PC, instruction memory and data memory.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC, 32'h8000_0000, reported on next_pc_o while rst_i is high

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- instr_i  in  32  current instruction
- pc_i  in  32  address of instr_i
- load_data_i  in  32  data-memory word at mem_addr_o (combinational read)
- next_pc_o  out  32  PC for next cycle
- jump_ok_o  out  1  taken branch/jump
- jump_pc_o  out  32  target when jump_ok_o, else 0
- alu_out_o  out  32  raw ALU result
- reg_we_o  out  1  register write this cycle
- reg_addr_o  out  5  rd when reg_we_o, else 0
- reg_data_o  out  32  writeback value when reg_we_o, else 0
- mem_we_o  out  1  store this cycle
- mem_addr_o  out  32  ALU address for loads/stores, else 0
- mem_wdata_o  out  32  rs2 value for stores, else 0
- mem_size_o  out  2  funct3[1:0]: 00 byte, 01 half, 10 word

Behaviour:
Register file:
- 32x32 registers with two combinational read ports (rs1 = instr[19:15], rs2 = instr[24:20]).
- x0 always reads 0.
- Write occurs on a rising clk_i edge when reg_we_o=1 and rd!=0.
- No read bypass; a written value is visible from the next cycle.
- rst_i asserted clears all registers immediately (asynchronous).
- While rst_i=1: reg_we_o=0, mem_we_o=0, jump_ok_o=0, next_pc_o=RESET_PC; other outputs stay combinational.

Immediates (all sign-extended):
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U = {instr[31:12], 12'b0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}

ALU:
- Operations: ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND, PASSB.
- Shift amount: instr[24:20] for immediate shifts, rs2[4:0] for register shifts.
- Arithmetic wraps modulo 2^32.

Per opcode:
- LUI 0110111: PASSB(U); rd write.
- AUIPC 0010111: pc+U; rd write.
- JAL 1101111: target pc+J; rd=pc+4; jump.
- JALR 1100111: target (rs1+I) & ~1; rd=pc+4; jump.
- BRANCH 1100011: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Taken -> jump_ok_o=1 with target pc+B. Other funct3 -> not taken. No rd write.
- LOAD 0000011: address rs1+I.
  - 000 LB: sign-extend load_data_i[7:0]
  - 001 LH: sign-extend [15:0]
  - 010 LW: full word
  - 100 LBU: zero-extend [7:0]
  - 101 LHU: zero-extend [15:0]
  - Other funct3: write 0.
- STORE 0100011: address rs1+S; mem_we_o=1 only for funct3 000/001/010; wdata=rs2.
- OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (SRA when instr[30]=1).
- OP 0110011: ADD/SUB (instr[30]), SLL, SLT, SLTU, XOR, SRL/SRA (instr[30]), OR, AND.
- Any other opcode (FENCE/SYSTEM/unknown): NOP; no writes, no jump.

Next PC and addresses:
- next_pc_o = jump_ok_o ? jump_pc_o : pc_i+4, with wrap at 2^32.
- Misaligned targets and addresses are passed through unchecked.

Optional Feature:
- Macro RV_ILLEGAL_FLAG_EN.
- Defined: adds output illegal_o (1 bit), high for an unknown opcode, a BRANCH/LOAD/STORE funct3 outside the lists above, or OP with instr[31:25] not in {0000000, 0100000}. illegal_o forces all writes and the jump off.
- Undefined: port absent; same instructions behave as NOP (undefined OP funct7 decodes by instr[30] only).

Test Plan:
- Reset, then ADDI x1,x0,5 at pc 0x80000000 -> reg_we_o=1, reg_addr_o=1, reg_data_o=5, next_pc_o=0x80000004. Next cycle ADD x2,x1,x1 -> reg_data_o=10.
- x1=0xFFFFFFF0: SRAI x3,x1,4 -> 0xFFFFFFFF; SRLI -> 0x0FFFFFFF; SLTU x4,x0,x1 -> 1; SLT x4,x1,x0 -> 1.
- BEQ x0,x0,-8 at pc 0x80000010 -> jump_ok_o=1, next_pc_o=0x80000008. BNE x0,x0 -> next_pc_o=0x80000014.
- JALR x1,x5,3 with x5=0x80000100 at pc 0x80000020 -> next_pc_o=0x80000102, reg_data_o=0x80000024.
- load_data_i=0x000080F0:
  - LB -> 0xFFFFFFF0
  - LBU -> 0x000000F0
  - LH -> 0xFFFF80F0
  - SW x2,8(x1) -> mem_we_o=1, mem_addr_o=x1+8, mem_size_o=10, reg_we_o=0.
- ADDI x0,x0,1 -> x0 still reads 0. rst_i pulsed mid-program -> all registers read 0 immediately, no write on that edge.
